tb_mem_responder: RTL and testbench
===================================

TB_MEM_RESPONDER -- requirements
Module: tb_mem_responder

Interface
REQ-001 The block SHALL have parameter PORTW, default 32, data word width in bits.
REQ-002 The block SHALL have parameter ADDRWIDTH, default 15, word address width; the array holds 2**ADDRWIDTH words.
REQ-003 The block SHALL have parameter LATENCY, default 1, read latency in cycles; legal range 1..4.
REQ-004 The block SHALL have parameter CNTW, default 32, width of the statistics counters.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rstx, input, 1, asynchronous active-low reset.
REQ-007 The block SHALL have port d, input, PORTW, write data.
REQ-008 The block SHALL have port addr, input, ADDRWIDTH, word address.
REQ-009 The block SHALL have port en_x, input, 1, active-low access enable.
REQ-010 The block SHALL have port wr_x, input, 1, active-low write select; 1 means read.
REQ-011 The block SHALL have port bit_wr_x, input, PORTW, active-low per-bit write enable.
REQ-012 The block SHALL have port mem_busy, input, 1, collision flag from the upstream arbiter.
REQ-013 The block SHALL have port q, output, PORTW, read data.
REQ-014 The block SHALL have port q_valid, output, 1, high for exactly one cycle per read, aligned with q.
REQ-015 The block SHALL have ports rd_cnt, wr_cnt and busy_cnt, each output, CNTW, statistics counters.

Function
REQ-016 The block SHALL sample an access at a rising clk edge when en_x=0; en_x=1 is idle, with no array, q or counter change except the pipeline shift.
REQ-017 For a write (en_x=0, wr_x=0), bit i of mem[addr] SHALL take d[i] where bit_wr_x[i]=0 and SHALL keep its value where bit_wr_x[i]=1.
REQ-018 A write with bit_wr_x all ones SHALL leave the array unchanged and SHALL still count as a write.
REQ-019 For a read (en_x=0, wr_x=1), mem[addr] SHALL be captured at edge N and presented on q with q_valid=1 after edge N+LATENCY-1, i.e. LATENCY cycles after the request cycle.
REQ-020 The read pipeline SHALL be a LATENCY-deep shift register of {valid, data}; it SHALL accept one new read per cycle with no bubbles.
REQ-021 q SHALL hold its last valid value while q_valid=0.
REQ-022 A read in the cycle directly after a write to the same address SHALL return the newly written data.
REQ-023 Only one access SHALL occur per cycle; a write and a read cannot coincide because wr_x selects one of them.
REQ-024 rd_cnt SHALL increment by 1 per sampled read, and wr_cnt SHALL increment by 1 per sampled write.
REQ-025 busy_cnt SHALL increment by 1 on each rising edge where mem_busy=1, regardless of en_x.
REQ-026 Each counter SHALL saturate at 2**CNTW-1 and SHALL NOT wrap.
REQ-027 Addresses SHALL use all ADDRWIDTH bits with no aliasing or masking.
REQ-028 An address input containing X/Z during an access SHALL produce an all-X q (read) or no array change (write), with a simulation warning.

Reset
REQ-029 While rstx=0, q_valid and all pipeline valid bits SHALL be 0, q SHALL be 0, and rd_cnt, wr_cnt and busy_cnt SHALL be 0, asynchronously.
REQ-030 Array contents SHALL NOT be modified by reset.
REQ-031 A read that is in flight when rstx falls SHALL be discarded and SHALL never assert q_valid.
REQ-032 No access SHALL be sampled on the first rising edge on which rstx=0; sampling resumes on the first rising edge after rstx returns to 1.

Verification
REQ-033 Full-mask write: with LATENCY=1, write 0xDEADBEEF to addr 0x0010 with bit_wr_x=0, then read 0x0010 -> q=0xDEADBEEF with q_valid=1 one cycle after the read; wr_cnt=1, rd_cnt=1.
REQ-034 Partial-mask write: with mem[5]=0xFFFFFFFF, write d=0x00000000 with bit_wr_x=0xFFFF0000, then read 5 -> q=0xFFFF0000.
REQ-035 Back-to-back reads: with LATENCY=3, reads of addr 1, 2, 3, 4 on consecutive cycles return the four words on consecutive cycles, starting 3 cycles after the first read; q_valid high for 4 cycles.
REQ-036 Reset mid-read: with LATENCY=4, assert rstx=0 two cycles after a read -> q_valid never rises and all counters=0, while previously written array words remain intact on a later read.
REQ-037 Collision and saturation: with CNTW=4, hold mem_busy=1 for 20 cycles -> busy_cnt=15; en_x=1 throughout -> rd_cnt=0 and wr_cnt=0.
REQ-038 Top address: write 0x12345678 to addr 2**ADDRWIDTH-1, then read it back -> q=0x12345678, and addr 0 is unchanged.

Source files
------------

// File: rtl/tb_mem_responder.sv
// rtl/tb_mem_responder.sv - behavioural memory responder with bit-masked writes, pipelined reads and statistics
module tb_mem_responder #(
  parameter int PORTW     = 32,
  parameter int ADDRWIDTH = 15,
  parameter int LATENCY   = 1,
  parameter int CNTW      = 32
) (
  input  logic                 clk,
  input  logic                 rstx,
  input  logic [PORTW-1:0]     d,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic                 en_x,
  input  logic                 wr_x,
  input  logic [PORTW-1:0]     bit_wr_x,
  input  logic                 mem_busy,
  output logic [PORTW-1:0]     q,
  output logic                 q_valid,
  output logic [CNTW-1:0]      rd_cnt,
  output logic [CNTW-1:0]      wr_cnt,
  output logic [CNTW-1:0]      busy_cnt
);

  localparam int DEPTH = 2 ** ADDRWIDTH;

  logic [PORTW-1:0] mem [DEPTH];
  logic             rd_acc;
  logic             wr_acc;
  logic             addr_bad;
  logic [PORTW-1:0] rd_word;

  logic [LATENCY-1:0] stage_valid;
  logic [PORTW-1:0]   stage_data [LATENCY];

  always_comb begin
    rd_acc   = !en_x && wr_x;
    wr_acc   = !en_x && !wr_x;
    addr_bad = $isunknown(addr);
    rd_word  = addr_bad ? {PORTW{1'bx}} : mem[addr];
  end

  // Array is never cleared; the reset branch only blocks writes while rstx is low.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
    end else if (wr_acc && !addr_bad) begin
      mem[addr] <= (mem[addr] & bit_wr_x) | (d & ~bit_wr_x);
    end
  end

  // Data only advances behind a valid bit, so the last stage holds the last read word.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      stage_valid <= '0;
      for (int i = 0; i < LATENCY; i++) stage_data[i] <= '0;
    end else begin
      stage_valid[0] <= rd_acc;
      if (rd_acc) stage_data[0] <= rd_word;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        if (stage_valid[i-1]) stage_data[i] <= stage_data[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      busy_cnt <= '0;
    end else begin
      assert (!(!en_x && addr_bad)) else $warning("tb_mem_responder: unknown address on access");
      if (rd_acc && rd_cnt != '1)     rd_cnt   <= rd_cnt + 1'b1;
      if (wr_acc && wr_cnt != '1)     wr_cnt   <= wr_cnt + 1'b1;
      if (mem_busy && busy_cnt != '1) busy_cnt <= busy_cnt + 1'b1;
    end
  end

  assign q       = stage_data[LATENCY-1];
  assign q_valid = stage_valid[LATENCY-1];

endmodule

// File: tb/tb_tb_mem_responder.sv
// tb/tb_tb_mem_responder.sv - directed bench for tb_mem_responder at latencies 1, 3 and 4
module tb_tb_mem_responder;

  logic        clk = 1'b0;
  logic        rstx;
  logic [31:0] d;
  logic [14:0] addr;
  logic        en_x;
  logic        wr_x;
  logic [31:0] bit_wr_x;
  logic        mem_busy;

  logic [31:0] q1, rc1, wc1, bc1;
  logic        qv1;
  logic [31:0] q3;
  logic [3:0]  rc3, wc3, bc3;
  logic        qv3;
  logic [31:0] q4, rc4, wc4, bc4;
  logic        qv4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tb_mem_responder #(.LATENCY(1)) u1 (
    .clk(clk), .rstx(rstx), .d(d), .addr(addr), .en_x(en_x), .wr_x(wr_x),
    .bit_wr_x(bit_wr_x), .mem_busy(mem_busy), .q(q1), .q_valid(qv1),
    .rd_cnt(rc1), .wr_cnt(wc1), .busy_cnt(bc1));

  tb_mem_responder #(.LATENCY(3), .CNTW(4)) u3 (
    .clk(clk), .rstx(rstx), .d(d), .addr(addr), .en_x(en_x), .wr_x(wr_x),
    .bit_wr_x(bit_wr_x), .mem_busy(mem_busy), .q(q3), .q_valid(qv3),
    .rd_cnt(rc3), .wr_cnt(wc3), .busy_cnt(bc3));

  tb_mem_responder #(.LATENCY(4)) u4 (
    .clk(clk), .rstx(rstx), .d(d), .addr(addr), .en_x(en_x), .wr_x(wr_x),
    .bit_wr_x(bit_wr_x), .mem_busy(mem_busy), .q(q4), .q_valid(qv4),
    .rd_cnt(rc4), .wr_cnt(wc4), .busy_cnt(bc4));

  task automatic apply_reset();
    rstx = 1'b0;
    @(negedge clk);
    rstx = 1'b1;
  endtask

  task automatic do_write(input logic [14:0] a, input logic [31:0] data, input logic [31:0] mask);
    en_x = 1'b0; wr_x = 1'b0; addr = a; d = data; bit_wr_x = mask;
    @(negedge clk);
    en_x = 1'b1; wr_x = 1'b1; bit_wr_x = '1;
  endtask

  task automatic start_read(input logic [14:0] a);
    en_x = 1'b0; wr_x = 1'b1; addr = a;
    @(negedge clk);
    en_x = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (qv1 !== 1'b0 || qv3 !== 1'b0 || qv4 !== 1'b0) begin miscompares++; $display("FAIL reset_qvalid got %b%b%b want 000", qv1, qv3, qv4); end
    vectors++; if (q1 !== 32'h0 || q3 !== 32'h0 || q4 !== 32'h0) begin miscompares++; $display("FAIL reset_q got %h %h %h want 0", q1, q3, q4); end
    vectors++; if (rc1 !== 32'h0 || wc1 !== 32'h0 || bc1 !== 32'h0) begin miscompares++; $display("FAIL reset_cnt got %0d %0d %0d want 0", rc1, wc1, bc1); end
  endtask

  task automatic test_full_mask();
    apply_reset();
    do_write(15'h0010, 32'hDEADBEEF, 32'h0);
    start_read(15'h0010);
    vectors++; if (qv1 !== 1'b1) begin miscompares++; $display("FAIL full_qvalid got %b want 1", qv1); end
    vectors++; if (q1 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL full_q got %h want deadbeef", q1); end
    vectors++; if (wc1 !== 32'd1 || rc1 !== 32'd1) begin miscompares++; $display("FAIL full_cnt got wr=%0d rd=%0d want 1 1", wc1, rc1); end
    @(negedge clk);
    vectors++; if (qv1 !== 1'b0 || q1 !== 32'hDEADBEEF) begin miscompares++; $display("FAIL full_hold got v=%b q=%h want 0 deadbeef", qv1, q1); end
  endtask

  task automatic test_partial_mask();
    apply_reset();
    do_write(15'd5, 32'hFFFFFFFF, 32'h0);
    do_write(15'd5, 32'h00000000, 32'hFFFF0000);
    do_write(15'd5, 32'h12345678, 32'hFFFFFFFF);
    start_read(15'd5);
    vectors++; if (qv1 !== 1'b1 || q1 !== 32'hFFFF0000) begin miscompares++; $display("FAIL partial_q got v=%b q=%h want 1 ffff0000", qv1, q1); end
    vectors++; if (wc1 !== 32'd3 || rc1 !== 32'd1) begin miscompares++; $display("FAIL partial_cnt got wr=%0d rd=%0d want 3 1", wc1, rc1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    int high;
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) do_write(15'(i + 1), words[i], 32'h0);
    apply_reset();
    high = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin en_x = 1'b0; wr_x = 1'b1; addr = 15'(i + 1); end
      else en_x = 1'b1;
      @(negedge clk);
      if (qv3) high++;
      if (i >= 2 && i <= 5) begin
        vectors++; if (qv3 !== 1'b1 || q3 !== words[i-2]) begin miscompares++; $display("FAIL b2b_word%0d got v=%b q=%h want 1 %h", i - 2, qv3, q3, words[i-2]); end
      end else begin
        vectors++; if (qv3 !== 1'b0) begin miscompares++; $display("FAIL b2b_idle%0d got v=%b want 0", i, qv3); end
      end
    end
    en_x = 1'b1;
    vectors++; if (high != 4 || q3 !== words[3]) begin miscompares++; $display("FAIL b2b_span got high=%0d q=%h want 4 44444444", high, q3); end
  endtask

  task automatic test_reset_mid_read();
    int rose;
    apply_reset();
    do_write(15'h0020, 32'hCAFEF00D, 32'h0);
    start_read(15'h0020);
    @(negedge clk);
    rstx = 1'b0;
    #1;
    vectors++; if (qv4 !== 1'b0 || rc4 !== 32'd0 || wc4 !== 32'd0 || bc4 !== 32'd0) begin miscompares++; $display("FAIL midrst_async got v=%b rd=%0d wr=%0d busy=%0d want 0", qv4, rc4, wc4, bc4); end
    @(negedge clk);
    rstx = 1'b1;
    rose = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (qv4 !== 1'b0) rose++;
    end
    vectors++; if (rose != 0) begin miscompares++; $display("FAIL midrst_discard got %0d valid cycles want 0", rose); end
    start_read(15'h0020);
    repeat (3) @(negedge clk);
    vectors++; if (qv4 !== 1'b1 || q4 !== 32'hCAFEF00D) begin miscompares++; $display("FAIL midrst_intact got v=%b q=%h want 1 cafef00d", qv4, q4); end
    vectors++; if (rc4 !== 32'd1 || wc4 !== 32'd0) begin miscompares++; $display("FAIL midrst_cnt got rd=%0d wr=%0d want 1 0", rc4, wc4); end
  endtask

  task automatic test_saturation();
    apply_reset();
    en_x = 1'b1;
    mem_busy = 1'b1;
    repeat (20) @(negedge clk);
    mem_busy = 1'b0;
    vectors++; if (bc3 !== 4'd15) begin miscompares++; $display("FAIL sat_busy got %0d want 15", bc3); end
    vectors++; if (rc3 !== 4'd0 || wc3 !== 4'd0) begin miscompares++; $display("FAIL sat_idle got rd=%0d wr=%0d want 0 0", rc3, wc3); end
    vectors++; if (bc1 !== 32'd20) begin miscompares++; $display("FAIL sat_wide got %0d want 20", bc1); end
  endtask

  task automatic test_top_addr();
    apply_reset();
    do_write(15'h0000, 32'h0BADF00D, 32'h0);
    do_write(15'h7FFF, 32'h12345678, 32'h0);
    start_read(15'h7FFF);
    vectors++; if (qv1 !== 1'b1 || q1 !== 32'h12345678) begin miscompares++; $display("FAIL top_q got v=%b q=%h want 1 12345678", qv1, q1); end
    start_read(15'h0000);
    vectors++; if (qv1 !== 1'b1 || q1 !== 32'h0BADF00D) begin miscompares++; $display("FAIL top_addr0 got v=%b q=%h want 1 0badf00d", qv1, q1); end
    start_read(15'h3FFF);
    vectors++; if (q1 === 32'h12345678) begin miscompares++; $display("FAIL top_alias got q=%h want not 12345678", q1); end
  endtask

  initial begin
    rstx = 1'b0; en_x = 1'b1; wr_x = 1'b1; d = '0; addr = '0;
    bit_wr_x = '1; mem_busy = 1'b0;
    test_reset();
    @(negedge clk);
    rstx = 1'b1;
    test_full_mask();
    test_partial_mask();
    test_back_to_back();
    test_reset_mid_read();
    test_saturation();
    test_top_addr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
